// File: rtl/ahb_lite_pkg.sv
// Shared AHB-Lite encodings and types for the two-master arbiter.
package ahb_lite_pkg;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_BUSY   = 2'b01;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [1:0] HTRANS_SEQ    = 2'b11;

  localparam logic [2:0] HBURST_SINGLE = 3'b000;
  localparam logic [2:0] HBURST_INCR   = 3'b001;
  localparam logic [2:0] HBURST_INCR4  = 3'b011;

  localparam logic [2:0] HSIZE_BYTE = 3'b000;
  localparam logic [2:0] HSIZE_HALF = 3'b001;
  localparam logic [2:0] HSIZE_WORD = 3'b010;

  typedef logic master_id_t;

  // Everything that travels with an address phase apart from the address itself.
  typedef struct packed {
    logic [1:0] htrans;
    logic       hwrite;
    logic [2:0] hsize;
    logic [2:0] hburst;
    logic [3:0] hprot;
    logic       hmastlock;
  } ahb_ctrl_t;

  function automatic logic is_active(input logic [1:0] htrans);
    return htrans[1];
  endfunction

endpackage

// File: rtl/ahb_lite_arb_in_stage.sv
// Per-master input stage: parks one address phase while the other master owns the bus
// and produces this master's hready.
module ahb_lite_arb_in_stage
  import ahb_lite_pkg::*;
#(
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [ADDR_W-1:0] haddr,
  input  ahb_ctrl_t         ctrl,
  input  logic              bus_hready,
  input  logic              is_addr_owner,
  input  logic              is_data_owner,
  output logic              hready,
  output logic              pending,
  output logic              req,
  output logic [ADDR_W-1:0] hold_addr,
  output ahb_ctrl_t         hold_ctrl
);

  always_comb begin
    if (is_data_owner)      hready = bus_hready;
    else if (pending)       hready = 1'b0;
    else if (is_addr_owner) hready = bus_hready;
    else                    hready = 1'b1;
  end

  assign req = pending | is_active(ctrl.htrans);

  // Capture does not depend on bus_hready: the master sees its address taken even
  // while the bus is stalled, and then waits here until it is issued.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pending   <= 1'b0;
      hold_addr <= '0;
      hold_ctrl <= '0;
    end else if (pending) begin
      if (bus_hready && is_addr_owner) pending <= 1'b0;
    end else if (hready && is_active(ctrl.htrans) && !is_addr_owner) begin
      pending   <= 1'b1;
      hold_addr <= haddr;
      hold_ctrl <= ctrl;
    end
  end

endmodule

// File: rtl/ahb_lite_master_arb.sv
// Two-master AHB-Lite arbiter: owner/data-phase tracking, round-robin grant,
// address/control and write-data muxes onto a single AHB-Lite master port.
module ahb_lite_master_arb
  import ahb_lite_pkg::*;
#(
  parameter int ADDR_W         = 32,
  parameter int DATA_W         = 32,
  parameter int DEFAULT_MASTER = 0
) (
  input  logic              HCLK,
  input  logic              HRESETn,
  input  logic [ADDR_W-1:0] m0_haddr,
  input  logic [1:0]        m0_htrans,
  input  logic              m0_hwrite,
  input  logic [2:0]        m0_hsize,
  input  logic [2:0]        m0_hburst,
  input  logic [3:0]        m0_hprot,
  input  logic              m0_hmastlock,
  input  logic [DATA_W-1:0] m0_hwdata,
  output logic              m0_hready,
  output logic              m0_hresp,
  output logic [DATA_W-1:0] m0_hrdata,
  input  logic [ADDR_W-1:0] m1_haddr,
  input  logic [1:0]        m1_htrans,
  input  logic              m1_hwrite,
  input  logic [2:0]        m1_hsize,
  input  logic [2:0]        m1_hburst,
  input  logic [3:0]        m1_hprot,
  input  logic              m1_hmastlock,
  input  logic [DATA_W-1:0] m1_hwdata,
  output logic              m1_hready,
  output logic              m1_hresp,
  output logic [DATA_W-1:0] m1_hrdata,
  output logic [ADDR_W-1:0] HADDR,
  output logic [1:0]        HTRANS,
  output logic              HWRITE,
  output logic [2:0]        HSIZE,
  output logic [2:0]        HBURST,
  output logic [3:0]        HPROT,
  output logic              HMASTLOCK,
  output logic [DATA_W-1:0] HWDATA,
  input  logic              HREADY,
  input  logic              HRESP,
  input  logic [DATA_W-1:0] HRDATA,
  output logic              hmaster
);

  // Handshake: an address phase is accepted on a rising edge with hready=1 and
  // htrans NONSEQ/SEQ; its data phase completes on the next rising edge with hready=1.

  localparam master_id_t DEFAULT_ID = master_id_t'(DEFAULT_MASTER != 0);

  master_id_t addr_owner, data_owner;
  logic       data_vld;

  ahb_ctrl_t         live0, live1, hold0, hold1, fwd_ctrl;
  logic [ADDR_W-1:0] hold_addr0, hold_addr1, fwd_addr;
  logic              pending0, pending1, req0, req1;
  logic              keep_owner, other_req;

  assign live0 = '{htrans: m0_htrans, hwrite: m0_hwrite, hsize: m0_hsize,
                   hburst: m0_hburst, hprot: m0_hprot, hmastlock: m0_hmastlock};
  assign live1 = '{htrans: m1_htrans, hwrite: m1_hwrite, hsize: m1_hsize,
                   hburst: m1_hburst, hprot: m1_hprot, hmastlock: m1_hmastlock};

  ahb_lite_arb_in_stage #(.ADDR_W(ADDR_W)) u_in0 (
    .clk           (HCLK),
    .rst_n         (HRESETn),
    .haddr         (m0_haddr),
    .ctrl          (live0),
    .bus_hready    (HREADY),
    .is_addr_owner (addr_owner == 1'b0),
    .is_data_owner (data_vld && data_owner == 1'b0),
    .hready        (m0_hready),
    .pending       (pending0),
    .req           (req0),
    .hold_addr     (hold_addr0),
    .hold_ctrl     (hold0)
  );

  ahb_lite_arb_in_stage #(.ADDR_W(ADDR_W)) u_in1 (
    .clk           (HCLK),
    .rst_n         (HRESETn),
    .haddr         (m1_haddr),
    .ctrl          (live1),
    .bus_hready    (HREADY),
    .is_addr_owner (addr_owner == 1'b1),
    .is_data_owner (data_vld && data_owner == 1'b1),
    .hready        (m1_hready),
    .pending       (pending1),
    .req           (req1),
    .hold_addr     (hold_addr1),
    .hold_ctrl     (hold1)
  );

  always_comb begin
    fwd_addr = m0_haddr;
    fwd_ctrl = live0;
    if (addr_owner == 1'b0) begin
      if (pending0) begin
        fwd_addr = hold_addr0;
        fwd_ctrl = hold0;
      end
      if (!req0) fwd_ctrl.htrans = HTRANS_IDLE;
    end else begin
      fwd_addr = pending1 ? hold_addr1 : m1_haddr;
      fwd_ctrl = pending1 ? hold1 : live1;
      if (!req1) fwd_ctrl.htrans = HTRANS_IDLE;
    end
  end

  assign HADDR     = fwd_addr;
  assign HTRANS    = fwd_ctrl.htrans;
  assign HWRITE    = fwd_ctrl.hwrite;
  assign HSIZE     = fwd_ctrl.hsize;
  assign HBURST    = fwd_ctrl.hburst;
  assign HPROT     = fwd_ctrl.hprot;
  assign HMASTLOCK = fwd_ctrl.hmastlock;
  assign hmaster   = addr_owner;

  assign HWDATA    = (data_owner == 1'b1) ? m1_hwdata : m0_hwdata;
  assign m0_hresp  = HRESP && data_vld && (data_owner == 1'b0);
  assign m1_hresp  = HRESP && data_vld && (data_owner == 1'b1);
  assign m0_hrdata = HRDATA;
  assign m1_hrdata = HRDATA;

  // Bursts and locked sequences hold the bus until their owner stops presenting them.
  assign keep_owner = is_active(fwd_ctrl.htrans) &&
                      (fwd_ctrl.hburst != HBURST_SINGLE || fwd_ctrl.hmastlock);
  assign other_req  = (addr_owner == 1'b0) ? req1 : req0;

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      addr_owner <= DEFAULT_ID;
      data_owner <= DEFAULT_ID;
      data_vld   <= 1'b0;
    end else if (HREADY) begin
      data_vld   <= is_active(fwd_ctrl.htrans);
      data_owner <= addr_owner;
      if (!keep_owner && other_req) addr_owner <= ~addr_owner;
    end
  end

endmodule

// File: tb/tb_ahb_lite_master_arb.sv
// Directed bench for ahb_lite_master_arb: both masters and the bus slave are driven
// cycle by cycle from one initial block with hand-computed expectations.
module tb_ahb_lite_master_arb;
  import ahb_lite_pkg::*;

  logic        HCLK, HRESETn;
  logic [31:0] m0_haddr, m1_haddr, m0_hwdata, m1_hwdata, m0_hrdata, m1_hrdata;
  logic [1:0]  m0_htrans, m1_htrans;
  logic        m0_hwrite, m1_hwrite, m0_hmastlock, m1_hmastlock;
  logic [2:0]  m0_hsize, m1_hsize, m0_hburst, m1_hburst;
  logic [3:0]  m0_hprot, m1_hprot;
  logic        m0_hready, m1_hready, m0_hresp, m1_hresp;
  logic [31:0] HADDR, HWDATA, HRDATA;
  logic [1:0]  HTRANS;
  logic        HWRITE, HMASTLOCK, HREADY, HRESP, hmaster;
  logic [2:0]  HSIZE, HBURST;
  logic [3:0]  HPROT;

  int n_vec = 0;
  int n_err = 0;

  ahb_lite_master_arb dut (
    .HCLK(HCLK), .HRESETn(HRESETn),
    .m0_haddr(m0_haddr), .m0_htrans(m0_htrans), .m0_hwrite(m0_hwrite), .m0_hsize(m0_hsize),
    .m0_hburst(m0_hburst), .m0_hprot(m0_hprot), .m0_hmastlock(m0_hmastlock),
    .m0_hwdata(m0_hwdata), .m0_hready(m0_hready), .m0_hresp(m0_hresp), .m0_hrdata(m0_hrdata),
    .m1_haddr(m1_haddr), .m1_htrans(m1_htrans), .m1_hwrite(m1_hwrite), .m1_hsize(m1_hsize),
    .m1_hburst(m1_hburst), .m1_hprot(m1_hprot), .m1_hmastlock(m1_hmastlock),
    .m1_hwdata(m1_hwdata), .m1_hready(m1_hready), .m1_hresp(m1_hresp), .m1_hrdata(m1_hrdata),
    .HADDR(HADDR), .HTRANS(HTRANS), .HWRITE(HWRITE), .HSIZE(HSIZE), .HBURST(HBURST),
    .HPROT(HPROT), .HMASTLOCK(HMASTLOCK), .HWDATA(HWDATA), .HREADY(HREADY), .HRESP(HRESP),
    .HRDATA(HRDATA), .hmaster(hmaster)
  );

  // Clock and reset
  initial begin
    HCLK = 1'b0;
    forever #5 HCLK = ~HCLK;
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Driver tasks
  task automatic tick();
    @(posedge HCLK);
    #1;
  endtask

  task automatic m0_set(input logic [31:0] a, input logic [1:0] t, input logic w,
                        input logic [2:0] b, input logic l);
    m0_haddr = a; m0_htrans = t; m0_hwrite = w; m0_hburst = b; m0_hmastlock = l;
  endtask

  task automatic m1_set(input logic [31:0] a, input logic [1:0] t, input logic w,
                        input logic [2:0] b, input logic l);
    m1_haddr = a; m1_htrans = t; m1_hwrite = w; m1_hburst = b; m1_hmastlock = l;
  endtask

  // Bus-port protocol check: a stalled active address phase must hold steady.
  logic        pc_vld = 1'b0;
  logic        pc_hready;
  logic [1:0]  pc_htrans;
  logic [31:0] pc_haddr;
  always @(negedge HCLK) begin
    if (!HRESETn) begin
      pc_vld = 1'b0;
    end else begin
      if (pc_vld && !pc_hready && pc_htrans[1]) begin
        chk("proto_haddr_stable", HADDR, pc_haddr);
        chk("proto_htrans_stable", HTRANS, pc_htrans);
      end
      pc_vld = 1'b1;
      pc_hready = HREADY;
      pc_htrans = HTRANS;
      pc_haddr = HADDR;
    end
  end

  initial begin
    HRESETn = 1'b0;
    HREADY = 1'b1; HRESP = 1'b0; HRDATA = '0;
    m0_set(32'h0, HTRANS_IDLE, 1'b0, HBURST_SINGLE, 1'b0);
    m1_set(32'h0, HTRANS_IDLE, 1'b0, HBURST_SINGLE, 1'b0);
    m0_hsize = HSIZE_WORD; m1_hsize = HSIZE_WORD;
    m0_hprot = 4'b0011;    m1_hprot = 4'b0011;
    m0_hwdata = '0;        m1_hwdata = '0;
    #2;
    chk("rst_hmaster", hmaster, 0);
    chk("rst_htrans", HTRANS, HTRANS_IDLE);
    chk("rst_hmastlock", HMASTLOCK, 0);
    chk("rst_m0_hready", m0_hready, 1);
    chk("rst_m1_hready", m1_hready, 1);
    chk("rst_m0_hresp", m0_hresp, 0);
    chk("rst_m1_hresp", m1_hresp, 0);
    #10 HRESETn = 1'b1;

    // 1: M0 alone, zero added latency
    tick(); m0_set(32'h100, HTRANS_NONSEQ, 1'b1, HBURST_SINGLE, 1'b0); #1;
    chk("t1_haddr", HADDR, 32'h100);
    chk("t1_htrans", HTRANS, HTRANS_NONSEQ);
    chk("t1_hwrite", HWRITE, 1);
    chk("t1_hmaster", hmaster, 0);
    chk("t1_m0_hready_hi", m0_hready, 1);
    HREADY = 1'b0; #1;
    chk("t1_m0_hready_lo", m0_hready, 0);
    HREADY = 1'b1;
    tick(); m0_set(32'h0, HTRANS_IDLE, 1'b0, HBURST_SINGLE, 1'b0); m0_hwdata = 32'h1111_1111; #1;
    chk("t1_hwdata", HWDATA, 32'h1111_1111);
    chk("t1_idle", HTRANS, HTRANS_IDLE);

    // 2: simultaneous singles, owner 0 goes first, M1 captured
    tick();
    m0_set(32'h104, HTRANS_NONSEQ, 1'b1, HBURST_SINGLE, 1'b0);
    m1_set(32'h300, HTRANS_NONSEQ, 1'b0, HBURST_SINGLE, 1'b0); #1;
    chk("t2a_haddr", HADDR, 32'h104);
    chk("t2a_hmaster", hmaster, 0);
    chk("t2a_m1_hready", m1_hready, 1);
    tick();
    m0_set(32'h0, HTRANS_IDLE, 1'b0, HBURST_SINGLE, 1'b0); m0_hwdata = 32'h2222_2222;
    m1_set(32'h0, HTRANS_IDLE, 1'b0, HBURST_SINGLE, 1'b0); #1;
    chk("t2b_hmaster", hmaster, 1);
    chk("t2b_haddr", HADDR, 32'h300);
    chk("t2b_htrans", HTRANS, HTRANS_NONSEQ);
    chk("t2b_hwrite", HWRITE, 0);
    chk("t2b_m1_hready", m1_hready, 0);
    chk("t2b_m0_hready", m0_hready, 1);
    chk("t2b_hwdata", HWDATA, 32'h2222_2222);
    tick(); HRDATA = 32'hCAFE_0001; #1;
    chk("t2c_m1_hready", m1_hready, 1);
    chk("t2c_m1_hrdata", m1_hrdata, 32'hCAFE_0001);
    chk("t2c_htrans", HTRANS, HTRANS_IDLE);
    chk("t2c_hmaster_park", hmaster, 1);

    // 3: M0 INCR4 is never split by M1
    tick(); m0_set(32'h200, HTRANS_NONSEQ, 1'b1, HBURST_INCR4, 1'b0); #1;
    chk("t3a_m0_hready", m0_hready, 1);
    chk("t3a_hmaster", hmaster, 1);
    tick();
    m0_set(32'h204, HTRANS_SEQ, 1'b1, HBURST_INCR4, 1'b0); m0_hwdata = 32'hA0;
    m1_set(32'h400, HTRANS_NONSEQ, 1'b1, HBURST_SINGLE, 1'b0); #1;
    chk("t3b_haddr", HADDR, 32'h200);
    chk("t3b_hburst", HBURST, HBURST_INCR4);
    chk("t3b_hmaster", hmaster, 0);
    chk("t3b_m0_hready", m0_hready, 0);
    chk("t3b_m1_hready", m1_hready, 1);
    tick();
    m1_set(32'h0, HTRANS_IDLE, 1'b0, HBURST_SINGLE, 1'b0); m1_hwdata = 32'h4444_4444; #1;
    chk("t3c_haddr", HADDR, 32'h204);
    chk("t3c_htrans", HTRANS, HTRANS_SEQ);
    chk("t3c_hwdata", HWDATA, 32'hA0);
    chk("t3c_m1_hready", m1_hready, 0);
    chk("t3c_m0_hready", m0_hready, 1);
    tick(); m0_set(32'h208, HTRANS_SEQ, 1'b1, HBURST_INCR4, 1'b0); m0_hwdata = 32'hA1; #1;
    chk("t3d_haddr", HADDR, 32'h208);
    chk("t3d_hmaster", hmaster, 0);
    chk("t3d_hwdata", HWDATA, 32'hA1);
    tick(); m0_set(32'h20C, HTRANS_SEQ, 1'b1, HBURST_INCR4, 1'b0); m0_hwdata = 32'hA2; #1;
    chk("t3e_haddr", HADDR, 32'h20C);
    chk("t3e_hmaster", hmaster, 0);
    tick(); m0_set(32'h0, HTRANS_IDLE, 1'b0, HBURST_SINGLE, 1'b0); m0_hwdata = 32'hA3; #1;
    chk("t3f_hmaster", hmaster, 0);
    chk("t3f_hwdata", HWDATA, 32'hA3);
    chk("t3f_m1_hready", m1_hready, 0);
    tick(); #1;
    chk("t3g_hmaster", hmaster, 1);
    chk("t3g_haddr", HADDR, 32'h400);
    chk("t3g_m1_hready", m1_hready, 0);
    tick(); #1;
    chk("t3h_hwdata", HWDATA, 32'h4444_4444);
    chk("t3h_m1_hready", m1_hready, 1);
    chk("t3h_htrans", HTRANS, HTRANS_IDLE);

    // 4: M0 locked read+write pair holds off M1
    tick();
    m0_set(32'h500, HTRANS_NONSEQ, 1'b0, HBURST_SINGLE, 1'b1);
    m1_set(32'h600, HTRANS_NONSEQ, 1'b0, HBURST_SINGLE, 1'b0); #1;
    chk("t4a_hmaster", hmaster, 1);
    chk("t4a_haddr", HADDR, 32'h600);
    chk("t4a_m0_hready", m0_hready, 1);
    tick();
    m0_set(32'h504, HTRANS_NONSEQ, 1'b1, HBURST_SINGLE, 1'b1);
    m1_set(32'h604, HTRANS_NONSEQ, 1'b0, HBURST_SINGLE, 1'b0); HRDATA = 32'hCAFE_0600; #1;
    chk("t4b_hmaster", hmaster, 0);
    chk("t4b_haddr", HADDR, 32'h500);
    chk("t4b_hmastlock", HMASTLOCK, 1);
    chk("t4b_m0_hready", m0_hready, 0);
    chk("t4b_m1_hready", m1_hready, 1);
    chk("t4b_m1_hrdata", m1_hrdata, 32'hCAFE_0600);
    tick(); m1_set(32'h0, HTRANS_IDLE, 1'b0, HBURST_SINGLE, 1'b0); #1;
    chk("t4c_haddr", HADDR, 32'h504);
    chk("t4c_hwrite", HWRITE, 1);
    chk("t4c_hmaster", hmaster, 0);
    chk("t4c_m1_hready", m1_hready, 0);
    tick(); m0_set(32'h0, HTRANS_IDLE, 1'b0, HBURST_SINGLE, 1'b0); m0_hwdata = 32'h5555_5555; #1;
    chk("t4d_hmaster_locked", hmaster, 0);
    chk("t4d_hmastlock", HMASTLOCK, 0);
    chk("t4d_hwdata", HWDATA, 32'h5555_5555);
    tick(); #1;
    chk("t4e_hmaster", hmaster, 1);
    chk("t4e_haddr", HADDR, 32'h604);
    chk("t4e_m1_hready", m1_hready, 0);
    tick(); #1;
    chk("t4f_m1_hready", m1_hready, 1);

    // 5: three wait states on an M1 write, then a two-cycle ERROR
    tick(); m1_set(32'h700, HTRANS_NONSEQ, 1'b1, HBURST_SINGLE, 1'b0); #1;
    chk("t5a_haddr", HADDR, 32'h700);
    chk("t5a_m1_hready", m1_hready, 1);
    tick(); m1_set(32'h0, HTRANS_IDLE, 1'b0, HBURST_SINGLE, 1'b0);
    m1_hwdata = 32'hDEAD_BEEF; HREADY = 1'b0;
    for (int i = 0; i < 3; i++) begin
      if (i > 0) tick();
      #1;
      chk("t5w_m1_hready", m1_hready, 0);
      chk("t5w_hwdata", HWDATA, 32'hDEAD_BEEF);
      chk("t5w_m0_hready", m0_hready, 1);
    end
    tick(); HREADY = 1'b1; #1;
    chk("t5d_m1_hready", m1_hready, 1);
    chk("t5d_hwdata", HWDATA, 32'hDEAD_BEEF);
    tick(); m1_set(32'h710, HTRANS_NONSEQ, 1'b0, HBURST_SINGLE, 1'b0); #1;
    tick(); m1_set(32'h0, HTRANS_IDLE, 1'b0, HBURST_SINGLE, 1'b0); HRESP = 1'b1; HREADY = 1'b0; #1;
    chk("t5e_m1_hresp", m1_hresp, 1);
    chk("t5e_m1_hready", m1_hready, 0);
    chk("t5e_m0_hresp", m0_hresp, 0);
    tick(); HREADY = 1'b1; #1;
    chk("t5f_m1_hresp", m1_hresp, 1);
    chk("t5f_m1_hready", m1_hready, 1);

    // 6: reset with M1 pending and an M0 data phase stalled on the bus
    tick(); HRESP = 1'b0; m0_set(32'h800, HTRANS_NONSEQ, 1'b1, HBURST_SINGLE, 1'b0); #1;
    chk("t6a_m0_hready", m0_hready, 1);
    chk("t6a_hmaster", hmaster, 1);
    tick(); m0_set(32'h0, HTRANS_IDLE, 1'b0, HBURST_SINGLE, 1'b0); m0_hwdata = 32'h8888_8888; #1;
    chk("t6b_hmaster", hmaster, 0);
    chk("t6b_haddr", HADDR, 32'h800);
    chk("t6b_m0_hready", m0_hready, 0);
    tick(); m1_set(32'h900, HTRANS_NONSEQ, 1'b1, HBURST_SINGLE, 1'b0); HREADY = 1'b0; #1;
    chk("t6c_m0_hready", m0_hready, 0);
    chk("t6c_m1_hready", m1_hready, 1);
    chk("t6c_hwdata", HWDATA, 32'h8888_8888);
    tick(); m1_set(32'h0, HTRANS_IDLE, 1'b0, HBURST_SINGLE, 1'b0); m1_hwdata = 32'h9999_9999; #1;
    chk("t6d_m1_hready", m1_hready, 0);
    chk("t6d_hmaster", hmaster, 0);
    HRESETn = 1'b0; HREADY = 1'b1; HRESP = 1'b1; #1;
    chk("t6r_m1_hready", m1_hready, 1);
    chk("t6r_m0_hready", m0_hready, 1);
    chk("t6r_htrans", HTRANS, HTRANS_IDLE);
    chk("t6r_hmaster", hmaster, 0);
    chk("t6r_m0_hresp", m0_hresp, 0);
    chk("t6r_m1_hresp", m1_hresp, 0);
    HRESP = 1'b0; #1;
    HRESETn = 1'b1;
    tick(); m0_set(32'hA00, HTRANS_NONSEQ, 1'b0, HBURST_SINGLE, 1'b0); #1;
    chk("t6e_haddr", HADDR, 32'hA00);
    chk("t6e_htrans", HTRANS, HTRANS_NONSEQ);
    chk("t6e_hmaster", hmaster, 0);
    tick(); m0_set(32'h0, HTRANS_IDLE, 1'b0, HBURST_SINGLE, 1'b0);
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
